// File: rtl/i2c_reg_pkg.sv
// Shared definitions for the I2C register-pointer controller and its register bank.
package i2c_reg_pkg;

  // Width of one register and of one I2C data byte.
  localparam int BYTE_W = 8;

  // Transaction sequencer states; the numeric values are visible on the debug port.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no transaction addressed to us
    ST_PTR   = 2'd1,  // next received byte loads the register pointer
    ST_WDATA = 2'd2,  // received bytes are written to reg[ptr]
    ST_RDATA = 2'd3   // master is reading; received bytes are a protocol error
  } state_t;

endpackage

// File: rtl/i2c_regfile.sv
// DEPTH x 8 register bank: one write port, two asynchronous read ports
// (transmit path and host path), every register resets to INIT.
module i2c_regfile
  import i2c_reg_pkg::*;
#(
  parameter int                DEPTH = 8,
  parameter logic [BYTE_W-1:0] INIT  = 8'h00,
  localparam int               AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [AW-1:0]     waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  logic [AW-1:0]     tx_addr,
  output logic [BYTE_W-1:0] tx_rdata,
  input  logic [AW-1:0]     host_addr,
  output logic [BYTE_W-1:0] host_rdata
);

  logic [BYTE_W-1:0] mem [DEPTH];

  // One flop group per register so each can be reset to INIT independently of any RAM inference.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_reg
    logic [BYTE_W-1:0] q_reg;

    // Load this register when the shared write port targets it.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        q_reg <= INIT;
      end else if (we && (waddr == AW'(gi))) begin
        q_reg <= wdata;
      end
    end

    assign mem[gi] = q_reg;
  end

  assign tx_rdata   = mem[tx_addr];
  assign host_rdata = mem[host_addr];

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Register-pointer controller: sequences I2C byte strobes into pointer loads,
// auto-incrementing register writes and reads, and arbitrates the register
// bank between I2C (priority) and a local host port.
module i2c_reg_ctrl
  import i2c_reg_pkg::*;
#(
  parameter int                DEPTH   = 8,
  parameter logic [BYTE_W-1:0] INIT    = 8'h00,
  parameter logic [DEPTH-1:0]  RO_MASK = '0,
  localparam int               AW      = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              txn_start,
  input  logic              txn_stop,
  input  logic              rx_valid,
  input  logic [BYTE_W-1:0] rx_data,
  input  logic              tx_req,
  output logic [BYTE_W-1:0] tx_data,
  output logic              tx_valid,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [AW-1:0]     host_addr,
  input  logic [BYTE_W-1:0] host_wdata,
  output logic              host_ack,
  output logic [BYTE_W-1:0] host_rdata,
  output logic [AW-1:0]     ptr,
  output logic [1:0]        state,
  output logic              err
);

  state_t            state_reg, state_next;
  logic [AW-1:0]     ptr_reg, ptr_next;
  logic              err_reg, err_next;
  logic [BYTE_W-1:0] tx_data_reg;
  logic              host_ack_reg;
  logic [BYTE_W-1:0] host_rdata_reg;

  logic              i2c_wr_cycle;  // an I2C data byte arrives in WDATA (even if read-only)
  logic              i2c_we;        // ...and it actually lands in the bank
  logic              host_sel;      // host access granted this cycle

  logic              rf_we;
  logic [AW-1:0]     rf_waddr;
  logic [BYTE_W-1:0] rf_wdata;
  logic [BYTE_W-1:0] rf_tx_rdata;
  logic [BYTE_W-1:0] rf_host_rdata;

  // Byte action for the current state first, then START/STOP override the next state.
  always_comb begin
    state_next   = state_reg;
    ptr_next     = ptr_reg;
    err_next     = err_reg;
    i2c_wr_cycle = 1'b0;
    i2c_we       = 1'b0;

    if (rx_valid) begin
      case (state_reg)
        ST_PTR: begin
          ptr_next   = rx_data[AW-1:0];
          state_next = ST_WDATA;
        end
        ST_WDATA: begin
          i2c_wr_cycle = 1'b1;
          i2c_we       = !RO_MASK[ptr_reg];
          ptr_next     = ptr_reg + AW'(1);
        end
        ST_RDATA: begin
          err_next = 1'b1;
        end
        default: ;
      endcase
    end else if (tx_req && (state_reg != ST_IDLE)) begin
      ptr_next   = ptr_reg + AW'(1);
      state_next = ST_RDATA;
    end

    if (txn_start) begin
      state_next = ST_PTR;
    end
    if (txn_stop) begin
      state_next = ST_IDLE;
    end
  end

  // Host only gets the write port in cycles without an incoming I2C data byte;
  // the held request is masked while its ack is showing so it is served once.
  always_comb begin
    host_sel = host_req && !host_ack_reg && !i2c_wr_cycle;
    rf_we    = i2c_we || (host_sel && host_we);
    rf_waddr = i2c_we ? ptr_reg : host_addr;
    rf_wdata = i2c_we ? rx_data : host_wdata;
  end

  // Sequencer, pointer, sticky error, transmit byte and host response registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg      <= ST_IDLE;
      ptr_reg        <= '0;
      err_reg        <= 1'b0;
      tx_data_reg    <= INIT;
      host_ack_reg   <= 1'b0;
      host_rdata_reg <= '0;
    end else begin
      state_reg    <= state_next;
      ptr_reg      <= ptr_next;
      err_reg      <= err_next;
      tx_data_reg  <= rf_tx_rdata;
      host_ack_reg <= host_sel;
      if (host_sel && !host_we) begin
        host_rdata_reg <= rf_host_rdata;
      end
    end
  end

  i2c_regfile #(
    .DEPTH (DEPTH),
    .INIT  (INIT)
  ) u_regfile (
    .clk        (clk),
    .rst        (rst),
    .we         (rf_we),
    .waddr      (rf_waddr),
    .wdata      (rf_wdata),
    .tx_addr    (ptr_reg),
    .tx_rdata   (rf_tx_rdata),
    .host_addr  (host_addr),
    .host_rdata (rf_host_rdata)
  );

  assign tx_data    = tx_data_reg;
  assign tx_valid   = (state_reg != ST_IDLE);
  assign host_ack   = host_ack_reg;
  assign host_rdata = host_rdata_reg;
  assign ptr        = ptr_reg;
  assign state      = state_reg;
  assign err        = err_reg;

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Bench for i2c_reg_ctrl: directed vector table, hand sequences for arbitration,
// error and reset corners, then random traffic against a transaction-level model.
module tb_i2c_reg_ctrl;

  localparam int           DEPTH   = 8;
  localparam int           AW      = 3;
  localparam logic [7:0]   INIT    = 8'h3C;
  localparam logic [7:0]   RO_MASK = 8'h02;

  localparam int OP_NONE = 0, OP_START = 1, OP_STOP = 2, OP_RX = 3, OP_TX = 4;

  logic          clk, rst;
  logic          txn_start, txn_stop, rx_valid, tx_req;
  logic [7:0]    rx_data;
  logic [7:0]    tx_data;
  logic          tx_valid;
  logic          host_req, host_we, host_ack;
  logic [AW-1:0] host_addr;
  logic [7:0]    host_wdata, host_rdata;
  logic [AW-1:0] ptr;
  logic [1:0]    state;
  logic          err;

  int total, bad;

  // Reference model: register contents, pointer, state number, sticky error.
  logic [7:0] m_regs [DEPTH];
  int         m_state, m_ptr;
  bit         m_err;

  i2c_reg_ctrl #(.DEPTH(DEPTH), .INIT(INIT), .RO_MASK(RO_MASK)) dut (
    .clk(clk), .rst(rst), .txn_start(txn_start), .txn_stop(txn_stop),
    .rx_valid(rx_valid), .rx_data(rx_data), .tx_req(tx_req), .tx_data(tx_data),
    .tx_valid(tx_valid), .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
    .host_wdata(host_wdata), .host_ack(host_ack), .host_rdata(host_rdata),
    .ptr(ptr), .state(state), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void m_reset();
    for (int i = 0; i < DEPTH; i++) m_regs[i] = INIT;
    m_state = 0;
    m_ptr   = 0;
    m_err   = 1'b0;
  endfunction

  // Transaction-level effect of one I2C strobe.
  function automatic void model_op(input int op, input logic [7:0] d);
    case (op)
      OP_START: m_state = 1;
      OP_STOP:  m_state = 0;
      OP_RX: begin
        if (m_state == 1) begin
          m_ptr   = d % DEPTH;
          m_state = 2;
        end else if (m_state == 2) begin
          if (!RO_MASK[m_ptr]) m_regs[m_ptr] = d;
          m_ptr = (m_ptr + 1) % DEPTH;
        end else if (m_state == 3) begin
          m_err = 1'b1;
        end
      end
      OP_TX: begin
        if (m_state != 0) begin
          m_ptr   = (m_ptr + 1) % DEPTH;
          m_state = 3;
        end
      end
      default: ;
    endcase
  endfunction

  // One I2C strobe (or none) with an optional concurrent host access, followed by a gap cycle.
  task automatic run_op(input int op, input logic [7:0] d, input bit h_en, input bit h_we,
                        input logic [AW-1:0] h_addr, input logic [7:0] h_wd,
                        output logic [7:0] sent, output logic [7:0] rdata);
    bit wr_cycle;
    int lat;
    sent  = tx_data;
    rdata = 8'h00;
    if (op == OP_TX && m_state != 0) check("tx_byte", tx_data, m_regs[m_ptr]);
    wr_cycle   = (op == OP_RX && m_state == 2);
    txn_start  = (op == OP_START);
    txn_stop   = (op == OP_STOP);
    rx_valid   = (op == OP_RX);
    tx_req     = (op == OP_TX);
    rx_data    = d;
    host_req   = h_en;
    host_we    = h_we;
    host_addr  = h_addr;
    host_wdata = h_wd;
    tick();
    txn_start = 1'b0;
    txn_stop  = 1'b0;
    rx_valid  = 1'b0;
    tx_req    = 1'b0;
    model_op(op, d);
    if (h_en) begin
      lat = 1;
      while (host_ack !== 1'b1 && lat < 6) begin
        tick();
        lat++;
      end
      check("host_ack_seen", host_ack, 1);
      check("host_latency", lat, wr_cycle ? 2 : 1);
      if (h_we) m_regs[h_addr] = h_wd;
      else      check("host_rdata", host_rdata, m_regs[h_addr]);
      rdata    = host_rdata;
      host_req = 1'b0;
    end
    tick();
    if (h_en) check("host_ack_pulse", host_ack, 0);
    check("state", state, m_state);
    check("ptr", ptr, m_ptr);
    check("err", err, m_err);
    check("tx_valid", tx_valid, m_state != 0);
  endtask

  typedef struct {
    int         op;
    logic [7:0] d;
    int         st;
    int         p;
    logic [7:0] tx;
  } vec_t;

  vec_t vecs [20];

  initial begin
    logic [7:0] sent, rd;
    logic [7:0] exp_regs [4];
    logic [AW-1:0] exp_addr [4];
    int op, r;
    bit h_en, h_we;
    logic [AW-1:0] h_addr;

    total = 0;
    bad   = 0;

    // Write AA,BB at 2; read them back; wrap at 7; read-only register 1.
    vecs = '{
      '{OP_START, 8'h00, 1, 0, 8'h00}, '{OP_RX, 8'h02, 2, 2, 8'h00},
      '{OP_RX,    8'hAA, 2, 3, 8'h00}, '{OP_RX, 8'hBB, 2, 4, 8'h00},
      '{OP_STOP,  8'h00, 0, 4, 8'h00},
      '{OP_START, 8'h00, 1, 4, 8'h00}, '{OP_RX, 8'h02, 2, 2, 8'h00},
      '{OP_START, 8'h00, 1, 2, 8'h00}, '{OP_TX, 8'h00, 3, 3, 8'hAA},
      '{OP_TX,    8'h00, 3, 4, 8'hBB}, '{OP_STOP, 8'h00, 0, 4, 8'h00},
      '{OP_START, 8'h00, 1, 4, 8'h00}, '{OP_RX, 8'h07, 2, 7, 8'h00},
      '{OP_RX,    8'h11, 2, 0, 8'h00}, '{OP_RX, 8'h22, 2, 1, 8'h00},
      '{OP_STOP,  8'h00, 0, 1, 8'h00},
      '{OP_START, 8'h00, 1, 1, 8'h00}, '{OP_RX, 8'h01, 2, 1, 8'h00},
      '{OP_RX,    8'h99, 2, 2, 8'h00}, '{OP_STOP, 8'h00, 0, 2, 8'h00}
    };

    txn_start = 0; txn_stop = 0; rx_valid = 0; tx_req = 0; rx_data = 0;
    host_req = 0; host_we = 0; host_addr = 0; host_wdata = 0;
    rst = 1'b0;
    tick();
    tick();
    check("rst_state", state, 0);
    check("rst_ptr", ptr, 0);
    check("rst_tx_data", tx_data, INIT);
    check("rst_tx_valid", tx_valid, 0);
    check("rst_host_ack", host_ack, 0);
    check("rst_host_rdata", host_rdata, 0);
    check("rst_err", err, 0);
    rst = 1'b1;
    m_reset();
    tick();

    for (int i = 0; i < 20; i++) begin
      run_op(vecs[i].op, vecs[i].d, 1'b0, 1'b0, '0, 8'h00, sent, rd);
      check("vec_state", state, vecs[i].st);
      check("vec_ptr", ptr, vecs[i].p);
      if (vecs[i].op == OP_TX) check("vec_tx_sent", sent, vecs[i].tx);
      check("vec_err", err, 0);
    end

    // Register contents left by the table, including the untouched read-only register.
    exp_addr = '{3'd2, 3'd3, 3'd7, 3'd0};
    exp_regs = '{8'hAA, 8'hBB, 8'h11, 8'h22};
    for (int i = 0; i < 4; i++) begin
      run_op(OP_NONE, 8'h00, 1'b1, 1'b0, exp_addr[i], 8'h00, sent, rd);
      check("table_reg", rd, exp_regs[i]);
    end
    run_op(OP_NONE, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, sent, rd);
    check("ro_reg_kept", rd, INIT);
    run_op(OP_NONE, 8'h00, 1'b1, 1'b1, 3'd1, 8'h99, sent, rd);
    run_op(OP_NONE, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00, sent, rd);
    check("ro_reg_host_write", rd, 8'h99);

    // Host write collides with an I2C write to the same register.
    run_op(OP_START, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_RX, 8'h05, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    rx_valid = 1'b1; rx_data = 8'h66;
    host_req = 1'b1; host_we = 1'b1; host_addr = 3'd5; host_wdata = 8'h55;
    tick();
    rx_valid = 1'b0;
    model_op(OP_RX, 8'h66);
    check("host_stalled", host_ack, 0);
    tick();
    check("host_ack_late", host_ack, 1);
    host_req = 1'b0;
    m_regs[5] = 8'h55;
    tick();
    check("collide_ptr", ptr, 6);
    run_op(OP_STOP, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_NONE, 8'h00, 1'b1, 1'b0, 3'd5, 8'h00, sent, rd);
    check("collide_host_final", rd, 8'h55);

    // Host write to the register under the pointer shows up on tx_data.
    run_op(OP_START, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_NONE, 8'h00, 1'b1, 1'b1, 3'd6, 8'h77, sent, rd);
    check("tx_follows_host_write", tx_data, 8'h77);

    // Byte received while the master reads -> sticky error.
    run_op(OP_RX, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_TX, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    check("rdata_sent_reg0", sent, 8'h22);
    run_op(OP_RX, 8'h44, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    check("err_set", err, 1);
    run_op(OP_START, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_STOP, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    check("err_sticky", err, 1);

    // Asynchronous reset in the middle of a register write.
    run_op(OP_START, 8'h00, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    run_op(OP_RX, 8'h03, 1'b0, 1'b0, '0, 8'h00, sent, rd);
    rx_valid = 1'b1; rx_data = 8'hEE;
    #2;
    rst = 1'b0;
    #1;
    check("arst_state", state, 0);
    check("arst_tx_valid", tx_valid, 0);
    check("arst_err", err, 0);
    check("arst_ptr", ptr, 0);
    check("arst_tx_data", tx_data, INIT);
    rx_valid = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    m_reset();
    tick();
    for (int i = 0; i < DEPTH; i++) begin
      run_op(OP_NONE, 8'h00, 1'b1, 1'b0, AW'(i), 8'h00, sent, rd);
      check("arst_reg_init", rd, INIT);
    end

    // Random traffic against the model.
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 99);
      if      (r < 12) op = OP_START;
      else if (r < 22) op = OP_STOP;
      else if (r < 62) op = OP_RX;
      else if (r < 85) op = OP_TX;
      else             op = OP_NONE;
      h_en   = (op == OP_NONE) || (op == OP_RX && $urandom_range(0, 2) == 0);
      h_we   = ($urandom_range(0, 1) == 1);
      h_addr = AW'($urandom_range(0, DEPTH - 1));
      run_op(op, 8'($urandom), h_en, h_we, h_addr, 8'($urandom), sent, rd);
    end

    // Final sweep of the whole bank.
    for (int i = 0; i < DEPTH; i++) begin
      run_op(OP_NONE, 8'h00, 1'b1, 1'b0, AW'(i), 8'h00, sent, rd);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
